pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stage-enable controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Drives fetch_enable/decode_enable/... that gate each stage register.
//  Handles instruction/data memory wait, load-use interlock and taken-branch redirect (delay slot kept).
//  Counts stall cycles for performance debug.
// PARAMETERS
//  REG_W        5   register address width (creg_addr_t)
//  LU_BUBBLES   1   bubbles inserted per load-use hazard (1..3)
//  CNT_W        32  width of stall_cycles counter (saturating)
// PORTS
//  clk               in   1      clock, all state updates on posedge
//  resetn            in   1      synchronous reset, active low
//  imem_ok           in   1      fetch data valid this cycle
//  dmem_req          in   1      MEM stage holds a load/store
//  dmem_ok           in   1      data access completes this cycle
//  id_rs, id_rt      in   REG_W  source registers of instruction in ID
//  id_use_rs/rt      in   1      ID instruction actually reads rs / rt
//  ex_load           in   1      EX instruction is a load
//  ex_dst            in   REG_W  EX destination register
//  id_branch_taken   in   1      branch/jump in ID resolved taken
//  fetch_enable      out  1      IF/PC register update
//  decode_enable     out  1      IF->ID register load
//  execute_enable    out  1      ID->EX register load
//  memory_enable     out  1      EX->MEM register load
//  writeback_enable  out  1      MEM->WB register load
//  ex_bubble         out  1      load NOP into ID->EX instead of ID data
//  redirect          out  1      PC takes branch target this cycle (1-cycle pulse)
//  stall_cycles      out  CNT_W  cycles with fetch_enable=0 since reset
// BEHAVIOUR
//  Reset: resetn=0 at posedge -> state RUN, lu_cnt=0, pend_redir=0, stall_cycles=0.
//   All enables, ex_bubble and redirect are forced 0 while resetn=0 (combinational gate).
//  Outputs are combinational from registered state + current inputs (0-cycle latency).
//  States: RUN, LU_STALL, DWAIT. Priority per cycle (highest first):
//   1 dmem_req & !dmem_ok -> full freeze: all five enables 0, ex_bubble 0; state DWAIT.
//     State LU_STALL/lu_cnt and pend_redir hold unchanged.
//     DWAIT exits in the cycle dmem_ok=1: normal evaluation resumes that same cycle.
//   2 load-use hazard = ex_load & ex_dst!=0 & ((id_use_rs & id_rs==ex_dst) | (id_use_rt & id_rt==ex_dst)):
//     fetch_enable=0, decode_enable=0, ex_bubble=1, execute/memory/writeback_enable=1.
//     Enter LU_STALL with lu_cnt=LU_BUBBLES-1; LU_STALL repeats the same outputs until lu_cnt==0,
//     decrementing each non-frozen cycle, then returns to RUN.
//     LU_BUBBLES=1 -> single bubble, no LU_STALL cycles.
//   3 !imem_ok -> fetch_enable=0, decode_enable=0, ex_bubble=1, downstream enables 1.
//   4 else all enables 1, ex_bubble 0.
//  Redirect:
//   - id_branch_taken in a cycle where decode_enable=1 -> redirect=1 that cycle.
//   - If decode_enable=0, set pend_redir; redirect=1 in the first later cycle with fetch_enable=1,
//     then clear pend_redir.
//   - Delay slot is never flushed; redirect never coincides with fetch_enable=0.
//   - A new id_branch_taken while pend_redir=1 is ignored (same ID instruction).
//  stall_cycles increments each cycle fetch_enable=0 and resetn=1; saturates at all-ones.
//  Reset mid-stall: resetn=0 discards DWAIT/LU_STALL/pend_redir; the first post-reset cycle is RUN.
// TESTING
//  T1 reset: resetn=0 two cycles -> all enables 0, stall_cycles=0; release with imem_ok=1 -> all enables 1.
//  T2 load-use: ex_load=1, ex_dst=5, id_rs=5, id_use_rs=1 -> one cycle fetch/decode_enable=0,
//     ex_bubble=1; with LU_BUBBLES=3 the same for 3 cycles, stall_cycles=3.
//  T3 dmem wait: dmem_req=1, dmem_ok=0 for 4 cycles during LU_STALL -> all enables 0 for 4 cycles,
//     lu_cnt frozen, bubbles resume after dmem_ok=1.
//  T4 ex_dst=0 with matching id_rs=0 -> no stall; ex_load=1 but id_use_rs=0 -> no stall.
//  T5 branch: id_branch_taken=1 with no stall -> redirect 1 for exactly one cycle.
//     With imem_ok=0 that cycle -> redirect pends, fires on first imem_ok=1 cycle.
//  T6 saturation: CNT_W=4, hold imem_ok=0 20 cycles -> stall_cycles sticks at 15.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Stage-enable controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
// Handles data-memory freeze, load-use bubbles, fetch wait and taken-branch
// redirect with the delay slot kept. It also counts the cycles in which fetch was stalled.
// The enables are combinational from the registered state plus the current inputs.

module pipeline_stall_ctrl #(
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             imem_ok,
    input  logic             dmem_req,
    input  logic             dmem_ok,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             id_branch_taken,
    output logic             fetch_enable,
    output logic             decode_enable,
    output logic             execute_enable,
    output logic             memory_enable,
    output logic             writeback_enable,
    output logic             ex_bubble,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_DWAIT    = 2'd2
    } state_t;

    localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       lu_cnt_r;
    logic [1:0]       lu_cnt_nxt_s;
    logic             pend_redir_r;
    logic             pend_redir_nxt_s;
    logic [CNT_W-1:0] stall_cycles_r;

    logic freeze_s;
    logic hazard_s;
    logic lu_active_s;

    // Hazard detection. A non-zero lu_cnt means that bubbles are still owed. That is
    // also true while a freeze is in progress, so the LU_STALL progress survives DWAIT.
    always_comb begin
        freeze_s    = dmem_req & ~dmem_ok;
        hazard_s    = ex_load & (ex_dst != {REG_W{1'b0}}) &
                      ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));
        lu_active_s = (lu_cnt_r != 2'd0);
    end

    // Next-state, stage enables and redirect generation, highest priority first.
    always_comb begin
        fetch_enable     = 1'b0;
        decode_enable    = 1'b0;
        execute_enable   = 1'b0;
        memory_enable    = 1'b0;
        writeback_enable = 1'b0;
        ex_bubble        = 1'b0;
        redirect         = 1'b0;
        state_nxt_s      = state_r;
        lu_cnt_nxt_s     = lu_cnt_r;
        pend_redir_nxt_s = pend_redir_r;

        if (!resetn) begin
            state_nxt_s      = ST_RUN;
            lu_cnt_nxt_s     = 2'd0;
            pend_redir_nxt_s = 1'b0;
        end else if (freeze_s) begin
            // Full freeze: every enable stays low and the hazard progress is held.
            state_nxt_s = ST_DWAIT;
        end else begin
            if (lu_active_s) begin
                execute_enable   = 1'b1;
                memory_enable    = 1'b1;
                writeback_enable = 1'b1;
                ex_bubble        = 1'b1;
                lu_cnt_nxt_s     = lu_cnt_r - 2'd1;
                state_nxt_s      = (lu_cnt_r == 2'd1) ? ST_RUN : ST_LU_STALL;
            end else if (hazard_s) begin
                execute_enable   = 1'b1;
                memory_enable    = 1'b1;
                writeback_enable = 1'b1;
                ex_bubble        = 1'b1;
                lu_cnt_nxt_s     = LU_RELOAD;
                state_nxt_s      = (LU_RELOAD != 2'd0) ? ST_LU_STALL : ST_RUN;
            end else if (!imem_ok) begin
                execute_enable   = 1'b1;
                memory_enable    = 1'b1;
                writeback_enable = 1'b1;
                ex_bubble        = 1'b1;
                state_nxt_s      = ST_RUN;
            end else begin
                fetch_enable     = 1'b1;
                decode_enable    = 1'b1;
                execute_enable   = 1'b1;
                memory_enable    = 1'b1;
                writeback_enable = 1'b1;
                state_nxt_s      = ST_RUN;
            end

            // Redirect only fires when fetch advances, so the delay slot is never lost.
            // While a redirect is pending, the same branch seen again in ID is ignored.
            if (fetch_enable) begin
                redirect         = pend_redir_r | id_branch_taken;
                pend_redir_nxt_s = 1'b0;
            end else if (id_branch_taken) begin
                pend_redir_nxt_s = 1'b1;
            end else begin
                pend_redir_nxt_s = pend_redir_r;
            end
        end
    end

    // State, bubble counter and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_RUN;
            lu_cnt_r     <= 2'd0;
            pend_redir_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lu_cnt_r     <= lu_cnt_nxt_s;
            pend_redir_r <= pend_redir_nxt_s;
        end
    end

    // Saturating count of the cycles in which fetch was held off.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!fetch_enable && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl
// This bench uses directed vectors on two instances that share their inputs.
// Instance a uses the default parameters. Instance b has LU_BUBBLES=3 and CNT_W=4.
// The output vector is {fetch, decode, execute, memory, writeback, ex_bubble, redirect}.

module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       resetn;
    logic       imem_ok;
    logic       dmem_req;
    logic       dmem_ok;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_load;
    logic [4:0] ex_dst;
    logic       id_branch_taken;

    logic        fe_a, de_a, ee_a, me_a, we_a, bub_a, red_a;
    logic [31:0] cnt_a;
    logic        fe_b, de_b, ee_b, me_b, we_b, bub_b, red_b;
    logic [3:0]  cnt_b;

    int checks_r;
    int failures_r;

    localparam logic [6:0] OUT_RUN    = 7'b1111100;
    localparam logic [6:0] OUT_REDIR  = 7'b1111101;
    localparam logic [6:0] OUT_STALL  = 7'b0011110;
    localparam logic [6:0] OUT_FROZEN = 7'b0000000;

    pipeline_stall_ctrl u_dut_a (
        .clk(clk), .resetn(resetn), .imem_ok(imem_ok), .dmem_req(dmem_req), .dmem_ok(dmem_ok),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_load(ex_load), .ex_dst(ex_dst), .id_branch_taken(id_branch_taken),
        .fetch_enable(fe_a), .decode_enable(de_a), .execute_enable(ee_a),
        .memory_enable(me_a), .writeback_enable(we_a), .ex_bubble(bub_a),
        .redirect(red_a), .stall_cycles(cnt_a)
    );

    pipeline_stall_ctrl #(.REG_W(5), .LU_BUBBLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .resetn(resetn), .imem_ok(imem_ok), .dmem_req(dmem_req), .dmem_ok(dmem_ok),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_load(ex_load), .ex_dst(ex_dst), .id_branch_taken(id_branch_taken),
        .fetch_enable(fe_b), .decode_enable(de_b), .execute_enable(ee_b),
        .memory_enable(me_b), .writeback_enable(we_b), .ex_bubble(bub_b),
        .redirect(red_b), .stall_cycles(cnt_b)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then leave 1 ns after the edge for new inputs to be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the combinational outputs settle, then compare both instances.
    task automatic chk_outs(input string tag, input logic [6:0] exp_a, input logic [6:0] exp_b);
        #2;
        chk_eq({tag, "_a"}, {25'd0, fe_a, de_a, ee_a, me_a, we_a, bub_a, red_a}, {25'd0, exp_a});
        chk_eq({tag, "_b"}, {25'd0, fe_b, de_b, ee_b, me_b, we_b, bub_b, red_b}, {25'd0, exp_b});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_a, input logic [3:0] exp_b);
        chk_eq({tag, "_cnt_a"}, cnt_a, exp_a);
        chk_eq({tag, "_cnt_b"}, {28'd0, cnt_b}, {28'd0, exp_b});
    endtask

    task automatic clear_hazard();
        ex_load   = 1'b0;
        ex_dst    = 5'd0;
        id_rs     = 5'd0;
        id_rt     = 5'd0;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
    endtask

    task automatic set_lu_hazard();
        ex_load   = 1'b1;
        ex_dst    = 5'd5;
        id_rs     = 5'd5;
        id_use_rs = 1'b1;
    endtask

    initial begin
        checks_r        = 0;
        failures_r      = 0;
        resetn          = 1'b0;
        imem_ok         = 1'b1;
        dmem_req        = 1'b0;
        dmem_ok         = 1'b0;
        id_branch_taken = 1'b0;
        clear_hazard();

        // T1: reset for two cycles, then release
        tick();
        chk_outs("rst_c1", OUT_FROZEN, OUT_FROZEN);
        tick();
        chk_outs("rst_c2", OUT_FROZEN, OUT_FROZEN);
        chk_cnt("rst", 32'd0, 4'd0);
        tick();
        resetn = 1'b1;
        chk_outs("rst_rel", OUT_RUN, OUT_RUN);

        // T2: load-use hazard, 1 bubble on a and 3 bubbles on b
        tick();
        set_lu_hazard();
        chk_outs("lu_c1", OUT_STALL, OUT_STALL);
        tick();
        clear_hazard();
        chk_outs("lu_c2", OUT_RUN, OUT_STALL);
        tick();
        chk_outs("lu_c3", OUT_RUN, OUT_STALL);
        tick();
        chk_outs("lu_done", OUT_RUN, OUT_RUN);
        chk_cnt("lu", 32'd1, 4'd3);

        // T3: data-memory freeze in the middle of an LU_STALL
        tick();
        set_lu_hazard();
        chk_outs("dw_haz", OUT_STALL, OUT_STALL);
        tick();
        clear_hazard();
        dmem_req = 1'b1;
        dmem_ok  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_outs("dw_frz", OUT_FROZEN, OUT_FROZEN);
            tick();
        end
        dmem_ok = 1'b1;
        chk_outs("dw_exit", OUT_RUN, OUT_STALL);
        tick();
        dmem_req = 1'b0;
        dmem_ok  = 1'b0;
        chk_outs("dw_b2", OUT_RUN, OUT_STALL);
        tick();
        chk_outs("dw_done", OUT_RUN, OUT_RUN);
        chk_cnt("dw", 32'd6, 4'd10);

        // T4: cases that must not stall
        ex_load   = 1'b1;
        ex_dst    = 5'd0;
        id_rs     = 5'd0;
        id_use_rs = 1'b1;
        chk_outs("nz_dst0", OUT_RUN, OUT_RUN);
        tick();
        ex_dst    = 5'd5;
        id_rs     = 5'd5;
        id_use_rs = 1'b0;
        id_rt     = 5'd3;
        id_use_rt = 1'b1;
        chk_outs("nz_nouse", OUT_RUN, OUT_RUN);
        tick();
        clear_hazard();

        // T5: immediate redirect, then a redirect that pends across a fetch wait
        id_branch_taken = 1'b1;
        chk_outs("br_now", OUT_REDIR, OUT_REDIR);
        tick();
        id_branch_taken = 1'b0;
        chk_outs("br_pulse", OUT_RUN, OUT_RUN);
        tick();
        id_branch_taken = 1'b1;
        imem_ok         = 1'b0;
        chk_outs("br_wait1", OUT_STALL, OUT_STALL);
        tick();
        id_branch_taken = 1'b0;
        chk_outs("br_wait2", OUT_STALL, OUT_STALL);
        tick();
        imem_ok = 1'b1;
        chk_outs("br_pend", OUT_REDIR, OUT_REDIR);
        tick();
        chk_outs("br_clear", OUT_RUN, OUT_RUN);
        chk_cnt("br", 32'd8, 4'd12);

        // T6: b's counter saturates, a's counter keeps counting
        imem_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk_cnt("sat", 32'd28, 4'd15);
        imem_ok = 1'b1;

        // Reset in the middle of an LU_STALL discards it
        tick();
        set_lu_hazard();
        tick();
        clear_hazard();
        resetn = 1'b0;
        chk_outs("rst_mid", OUT_FROZEN, OUT_FROZEN);
        tick();
        resetn = 1'b1;
        chk_outs("rst_post", OUT_RUN, OUT_RUN);
        chk_cnt("rst_post", 32'd0, 4'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
